// File: rtl/rxiod_eye_train_ctrl_if.sv
// Bring-up / IOD bundle for the RX eye-training controller.
// master: fabric bring-up logic and IOD lanes (drive start and eye flags).
// slave : the training controller (drives delay-line controls and status).
interface rxiod_eye_train_ctrl_if #(
    parameter int LANES = 4,
    parameter int TAP_W = 8
);
    logic                     TRAIN_START;
    logic [LANES-1:0]         EYE_MONITOR_EARLY;
    logic [LANES-1:0]         EYE_MONITOR_LATE;
    logic [LANES-1:0]         DELAY_LINE_LOAD;
    logic [LANES-1:0]         DELAY_LINE_MOVE;
    logic [LANES-1:0]         DELAY_LINE_DIRECTION;
    logic [LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS;
    logic                     TRAIN_BUSY;
    logic                     TRAIN_DONE;
    logic [LANES-1:0]         TRAIN_ERR;
    logic [LANES*TAP_W-1:0]   LANE_TAP;

    modport master (
        output TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
        input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, LANE_TAP
    );

    modport slave (
        input  TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
        output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
               EYE_MONITOR_CLEAR_FLAGS, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, LANE_TAP
    );
endinterface

// File: rtl/rxiod_eye_train_ctrl.sv
// Multi-lane RX delay-training controller. Lanes are trained one after another:
// each lane's delay line is swept from tap 0 to MAX_TAPS-1, the OR of the early/late
// eye flags is accumulated per tap, the longest clean run is tracked (earliest wins
// on ties) and the delay line is walked back to the centre of that run.
// Optional build macro RXIOD_TRAIN_MIN_EYE_EN: windows shorter than MIN_EYE are
// rejected as failures (lane flagged in TRAIN_ERR and reloaded to tap 0).
module rxiod_eye_train_ctrl #(
    parameter int LANES      = 4,
    parameter int TAP_W      = 8,
    parameter int MAX_TAPS   = 128,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_CYC = 16,
    parameter int MIN_EYE    = 8
) (
    input  logic                 FAB_CLK,
    input  logic                 RX_SYNC_RST,
    rxiod_eye_train_ctrl_if.slave bus
);
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LEN_W   = TAP_W + 1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_CLEAR  = 4'd2,
        ST_SETTLE = 4'd3,
        ST_SAMPLE = 4'd4,
        ST_EVAL   = 4'd5,
        ST_STEP   = 4'd6,
        ST_CALC   = 4'd7,
        ST_RELOAD = 4'd8,
        ST_CENTER = 4'd9,
        ST_GAP    = 4'd10,
        ST_NEXT   = 4'd11,
        ST_DONE   = 4'd12
    } state_t;

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [TAP_W-1:0]       tap_q, tap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic [LEN_W-1:0]       run_len_q, run_len_d;
    logic [TAP_W-1:0]       run_start_q, run_start_d;
    logic [LEN_W-1:0]       best_len_q, best_len_d;
    logic [TAP_W-1:0]       best_start_q, best_start_d;
    logic [TAP_W-1:0]       centre_q, centre_d;
    logic [LANES-1:0]       load_q, load_d;
    logic [LANES-1:0]       move_q, move_d;
    logic [LANES-1:0]       dir_q, dir_d;
    logic [LANES-1:0]       clr_q, clr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [LANES-1:0]       err_q, err_d;
    logic [LANES*TAP_W-1:0] lane_tap_q, lane_tap_d;

    logic [LANES-1:0]       lane_oh_s;
    logic [LANES*TAP_W-1:0] slot_mask_s;
    logic [LANES*TAP_W-1:0] centre_slot_s;
    logic                   flag_s;
    logic [LEN_W-1:0]       run_new_s;
    logic [LEN_W-1:0]       eff_len_s;
    logic [TAP_W-1:0]       centre_s;
    logic                   tap_last_s;

`ifdef RXIOD_TRAIN_MIN_EYE_EN
    // Short windows are scored as no window at all.
    always_comb begin
        if (best_len_q < LEN_W'(MIN_EYE)) begin
            eff_len_s = '0;
        end else begin
            eff_len_s = best_len_q;
        end
    end
`else
    logic [31:0] min_eye_unused_s;
    assign min_eye_unused_s = 32'(MIN_EYE);

    // Any non-empty window is accepted.
    always_comb begin
        eff_len_s = best_len_q;
    end
`endif

    // Active-lane one-hot and the LANE_TAP slot belonging to it.
    always_comb begin
        lane_oh_s     = '0;
        slot_mask_s   = '0;
        centre_slot_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_oh_s[i] = (lane_q == LANE_W'(i));
            slot_mask_s[i*TAP_W +: TAP_W]   = {TAP_W{lane_oh_s[i]}};
            centre_slot_s[i*TAP_W +: TAP_W] = centre_s & {TAP_W{lane_oh_s[i]}};
        end
    end

    assign flag_s     = |((bus.EYE_MONITOR_EARLY | bus.EYE_MONITOR_LATE) & lane_oh_s);
    assign run_new_s  = acc_q ? {LEN_W{1'b0}} : (run_len_q + LEN_W'(1));
    assign centre_s   = best_start_q + best_len_q[TAP_W:1];
    assign tap_last_s = (tap_q == TAP_W'(MAX_TAPS - 1));

    // Next-state and next-output computation for the training sequencer.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        centre_d     = centre_q;
        load_d       = '0;
        move_d       = '0;
        dir_d        = '0;
        clr_d        = '0;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        lane_tap_d   = lane_tap_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.TRAIN_START) begin
                    done_d     = 1'b0;
                    err_d      = '0;
                    lane_tap_d = '0;
                    busy_d     = 1'b1;
                    lane_d     = '0;
                    state_d    = ST_LOAD;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_d       = lane_oh_s;
                tap_d        = '0;
                best_len_d   = '0;
                best_start_d = '0;
                run_len_d    = '0;
                run_start_d  = '0;
                state_d      = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_d   = lane_oh_s;
                acc_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                acc_d = acc_q | flag_s;
                if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_EVAL;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_EVAL: begin
                run_len_d = run_new_s;
                if (!acc_q && (run_len_q == '0)) begin
                    run_start_d = tap_q;
                end else begin
                    run_start_d = run_start_q;
                end
                // Strictly greater: the earliest of equal-length windows is kept.
                if (run_new_s > best_len_q) begin
                    best_len_d   = run_new_s;
                    best_start_d = (run_len_q == '0) ? tap_q : run_start_q;
                end else begin
                    best_len_d   = best_len_q;
                end
                state_d = tap_last_s ? ST_CALC : ST_STEP;
            end
            ST_STEP: begin
                move_d  = lane_oh_s;
                dir_d   = lane_oh_s;
                tap_d   = tap_q + TAP_W'(1);
                state_d = ST_CLEAR;
            end
            ST_CALC: begin
                if (eff_len_s == '0) begin
                    err_d      = err_q | lane_oh_s;
                    lane_tap_d = lane_tap_q & ~slot_mask_s;
                    state_d    = ST_RELOAD;
                end else begin
                    centre_d   = centre_s;
                    lane_tap_d = (lane_tap_q & ~slot_mask_s) | centre_slot_s;
                    state_d    = (centre_s == tap_q) ? ST_NEXT : ST_CENTER;
                end
            end
            ST_RELOAD: begin
                load_d  = lane_oh_s;
                tap_d   = '0;
                state_d = ST_NEXT;
            end
            ST_CENTER: begin
                // The centre never lies above the last swept tap, so this only walks down.
                if (tap_q > centre_q) begin
                    move_d  = lane_oh_s;
                    tap_d   = tap_q - TAP_W'(1);
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_GAP: begin
                state_d = (tap_q == centre_q) ? ST_NEXT : ST_CENTER;
            end
            ST_NEXT: begin
                if (lane_q == LANE_W'(LANES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    lane_d  = lane_q + LANE_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any training in progress.
    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            tap_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            centre_q     <= '0;
            load_q       <= '0;
            move_q       <= '0;
            dir_q        <= '0;
            clr_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
            lane_tap_q   <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            centre_q     <= centre_d;
            load_q       <= load_d;
            move_q       <= move_d;
            dir_q        <= dir_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            lane_tap_q   <= lane_tap_d;
        end
    end

    assign bus.DELAY_LINE_LOAD         = load_q;
    assign bus.DELAY_LINE_MOVE         = move_q;
    assign bus.DELAY_LINE_DIRECTION    = dir_q;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign bus.TRAIN_BUSY              = busy_q;
    assign bus.TRAIN_DONE              = done_q;
    assign bus.TRAIN_ERR               = err_q;
    assign bus.LANE_TAP                = lane_tap_q;
endmodule

// File: tb/tb_rxiod_eye_train_ctrl.sv
// Directed bench for rxiod_eye_train_ctrl: a small delay-line model per lane tracks
// the tap position from LOAD/MOVE pulses and raises eye flags on taps outside the
// configured clean mask.
module tb_rxiod_eye_train_ctrl;
    localparam int LANES = 2;
    localparam int TAP_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rxiod_eye_train_ctrl_if #(.LANES(LANES), .TAP_W(TAP_W)) bus ();

    rxiod_eye_train_ctrl #(
        .LANES(LANES), .TAP_W(TAP_W), .MAX_TAPS(16),
        .SETTLE_CYC(2), .SAMPLE_CYC(4), .MIN_EYE(8)
    ) dut (
        .FAB_CLK(clk),
        .RX_SYNC_RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Delay-line / eye-monitor model state
    logic [15:0] clean_mask [2];
    int pos [2];
    int loads [2];
    int incs [2];
    int decs [2];
    int viol;
    int first_load_lane;
    int cyc;
    int t_first;
    int t_second;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 2; i++) begin
            loads[i] = 0;
            incs[i]  = 0;
            decs[i]  = 0;
        end
        viol            = 0;
        first_load_lane = -1;
        t_first         = 0;
        t_second        = 0;
    endtask

    // Delay-line model and flag generation, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if ($countones(bus.DELAY_LINE_LOAD) > 1 || $countones(bus.DELAY_LINE_MOVE) > 1 ||
            $countones(bus.EYE_MONITOR_CLEAR_FLAGS) > 1 ||
            (bus.DELAY_LINE_DIRECTION & ~bus.DELAY_LINE_MOVE) != 2'b00) begin
            viol = viol + 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.DELAY_LINE_LOAD[i]) begin
                pos[i]   = 0;
                loads[i] = loads[i] + 1;
                if (first_load_lane < 0) first_load_lane = i;
            end
            if (bus.DELAY_LINE_MOVE[i]) begin
                if (bus.DELAY_LINE_DIRECTION[i]) begin
                    pos[i]  = pos[i] + 1;
                    incs[i] = incs[i] + 1;
                    if (i == 0 && incs[0] == 1) t_first = cyc;
                    if (i == 0 && incs[0] == 2) t_second = cyc;
                end else begin
                    pos[i]  = pos[i] - 1;
                    decs[i] = decs[i] + 1;
                end
            end
            if (pos[i] >= 0 && pos[i] < 16 && clean_mask[i][pos[i]]) begin
                bus.EYE_MONITOR_EARLY[i] = 1'b0;
                bus.EYE_MONITOR_LATE[i]  = 1'b0;
            end else begin
                bus.EYE_MONITOR_EARLY[i] = (pos[i] < 8);
                bus.EYE_MONITOR_LATE[i]  = (pos[i] >= 8);
            end
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        bus.TRAIN_START = 1'b1;
        @(negedge clk);
        bus.TRAIN_START = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.TRAIN_DONE) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_lane(input string tag, input int ln, input int exp_tap,
                              input int exp_err, input int exp_loads, input int exp_decs);
        logic [TAP_W-1:0] tap_v;
        tap_v = bus.LANE_TAP[ln*TAP_W +: TAP_W];
        chk({tag, "_tap"},   32'(tap_v), 32'(exp_tap));
        chk({tag, "_err"},   32'(bus.TRAIN_ERR[ln]), 32'(exp_err));
        chk({tag, "_pos"},   32'(pos[ln]), 32'(exp_tap));
        chk({tag, "_incs"},  32'(incs[ln]), 32'd15);
        chk({tag, "_decs"},  32'(decs[ln]), 32'(exp_decs));
        chk({tag, "_loads"}, 32'(loads[ln]), 32'(exp_loads));
    endtask

    initial begin
        bus.TRAIN_START       = 1'b0;
        bus.EYE_MONITOR_EARLY = 2'b00;
        bus.EYE_MONITOR_LATE  = 2'b00;
        clean_mask[0] = 16'h0000;
        clean_mask[1] = 16'h0000;
        pos[0] = 0;
        pos[1] = 0;
        cyc    = 0;
        clr_model();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.TRAIN_BUSY), 32'd0);
        chk("rst_done", 32'(bus.TRAIN_DONE), 32'd0);
        chk("rst_err", 32'(bus.TRAIN_ERR), 32'd0);
        chk("rst_tap", 32'(bus.LANE_TAP), 32'd0);
        chk("rst_pulses", 32'({bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE,
                                bus.DELAY_LINE_DIRECTION, bus.EYE_MONITOR_CLEAR_FLAGS}), 32'd0);

        // A: single windows per lane, lane1 picks the longer of two windows
        clean_mask[0] = 16'h0FF0;
        clean_mask[1] = 16'h3F1C;
        clr_model();
        start_pulse();
        chk("a_busy_set", 32'(bus.TRAIN_BUSY), 32'd1);
        wait_done("a_done");
        @(negedge clk);
        chk("a_busy_drop", 32'(bus.TRAIN_BUSY), 32'd0);
        chk("a_done_sticky", 32'(bus.TRAIN_DONE), 32'd1);
        check_lane("a_l0", 0, 8, 0, 1, 7);
        check_lane("a_l1", 1, 11, 0, 1, 4);
        chk("a_dwell", 32'(t_second - t_first), 32'd9);
        chk("a_onehot", 32'(viol), 32'd0);

        // B: equal windows keep the earliest; lane1 fully clean
        clean_mask[0] = 16'h01CE;
        clean_mask[1] = 16'hFFFF;
        clr_model();
        start_pulse();
        chk("b_done_cleared", 32'(bus.TRAIN_DONE), 32'd0);
        wait_done("b_done");
        check_lane("b_l0", 0, 2, 0, 1, 13);
        check_lane("b_l1", 1, 8, 0, 1, 7);

        // C: lane0 never clean, lane1 clean only on the last tap
        clean_mask[0] = 16'h0000;
        clean_mask[1] = 16'h8000;
        clr_model();
        start_pulse();
        wait_done("c_done");
        check_lane("c_l0", 0, 0, 1, 2, 0);
        check_lane("c_l1", 1, 15, 0, 1, 0);

        // D: reset in the middle of lane0 at tap 6, then restart
        clean_mask[0] = 16'h0FF0;
        clean_mask[1] = 16'h3F1C;
        clr_model();
        start_pulse();
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (pos[0] == 6) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("d_reach_tap6", 32'(hit), 32'd1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("d_rst_busy", 32'(bus.TRAIN_BUSY), 32'd0);
        chk("d_rst_outs", 32'({bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION,
                                bus.EYE_MONITOR_CLEAR_FLAGS, bus.TRAIN_ERR, bus.TRAIN_DONE}), 32'd0);
        chk("d_rst_tap", 32'(bus.LANE_TAP), 32'd0);
        rst = 1'b0;
        clr_model();
        repeat (40) @(negedge clk);
        chk("d_quiet", 32'(loads[0] + loads[1] + incs[0] + incs[1] + decs[0] + decs[1]), 32'd0);
        pos[0] = 6;
        start_pulse();
        wait_done("d_done");
        chk("d_first_lane", 32'(first_load_lane), 32'd0);
        check_lane("d_l0", 0, 8, 0, 1, 7);
        check_lane("d_l1", 1, 11, 0, 1, 4);

        // E: start held high through training; 6-tap window vs MIN_EYE
        clean_mask[0] = 16'h03F0;
        clean_mask[1] = 16'hFFFF;
        clr_model();
        @(negedge clk);
        bus.TRAIN_START = 1'b1;
        wait_done("e_done");
        bus.TRAIN_START = 1'b0;
        repeat (3) @(negedge clk);
        chk("e_no_restart_busy", 32'(bus.TRAIN_BUSY), 32'd0);
`ifdef RXIOD_TRAIN_MIN_EYE_EN
        check_lane("e_l0", 0, 0, 1, 2, 0);
`else
        check_lane("e_l0", 0, 7, 0, 1, 8);
`endif
        check_lane("e_l1", 1, 8, 0, 1, 7);
        chk("e_onehot", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
